csa_pipe_addsub: RTL and testbench

- Parametrised, pipelined carry-select adder/subtractor. Successor to the combinational carry-select adder.
- The operand is split into WIDTH/BLOCK carry-select blocks, spread evenly over STAGES register stages.
- Adds a per-transaction add/sub mode, signed-overflow and carry flags, and a valid/ready handshake on both sides.
- Sits in the arithmetic datapath between the Booth partial-product reducer and the result register.

---
 rtl/csa_pipe_addsub.sv | 179 +++++++++++++++++
 tb/tb_csa_pipe_addsub.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csa_pipe_addsub.sv
// csa_pipe_addsub
//   Pipelined carry-select adder/subtractor. The operand is cut into
//   WIDTH/BLOCK carry-select blocks, and every pipeline stage handles the
//   same number of consecutive blocks. Each block holds two ripple-carry
//   adders, one with carry-in 0 and one with carry-in 1. The carry selected
//   by the previous block drives the mux that picks between them.
//
//   Ports
//     clk        rising-edge clock
//     rst_n      asynchronous active-low reset
//     in_valid   input transaction valid
//     in_ready   block accepts the input this cycle
//     a, b       operands, WIDTH bits
//     carry_i    carry-in for add; ignored when sub=1
//     sub        0: a+b+carry_i   1: a-b (a + ~b + 1)
//     out_valid  result valid
//     out_ready  downstream accepts the result
//     sum        result modulo 2^WIDTH
//     carry_o    carry out of the MSB (for sub, 1 = no borrow)
//     ovf        two's-complement overflow
//
//   Latency is STAGES cycles and throughput is one result per cycle. A single
//   global enable stalls every stage together, so bubbles are never squeezed
//   out of the pipeline.

module csa_pipe_addsub #(
  parameter int WIDTH  = 32,
  parameter int BLOCK  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_i,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_o,
  output logic             ovf
);

  localparam int NBLK     = WIDTH / BLOCK;
  localparam int STG_SAFE = (STAGES > 0) ? STAGES : 1;
  localparam int NPS      = NBLK / STG_SAFE;   // blocks per stage

  if ((WIDTH % BLOCK) != 0 || STAGES < 1 || STAGES > NBLK ||
      (NBLK % STG_SAFE) != 0) begin : g_param_check
    $error("csa_pipe_addsub: illegal WIDTH=%0d BLOCK=%0d STAGES=%0d",
           WIDTH, BLOCK, STAGES);
  end

  // Plain ripple-carry adder for one block; result is {carry_out, sum}.
  function automatic logic [BLOCK:0] rca(input logic [BLOCK-1:0] x,
                                         input logic [BLOCK-1:0] y,
                                         input logic             cin);
    logic [BLOCK:0] r;
    logic           c;
    r = '0;
    c = cin;
    for (int i = 0; i < BLOCK; i++) begin
      r[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    r[BLOCK] = c;
    return r;
  endfunction

  logic             w_en;
  logic [WIDTH-1:0] w_b_eff;
  logic             w_c0;

  // Subtraction is a + ~b + 1, so the forced carry-in supplies the +1.
  assign w_b_eff = sub ? ~b : b;
  assign w_c0    = sub | carry_i;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] w_a_in;
    logic [WIDTH-1:0] w_b_in;
    logic [WIDTH-1:0] w_s_in;
    logic             w_c_in;
    logic             w_sub_in;
    logic             w_vld_in;
    logic [WIDTH-1:0] w_s_out;
    logic             w_c_out;
    logic [BLOCK:0]   w_r0;
    logic [BLOCK:0]   w_r1;
    logic             w_cc;
    logic             w_unused_ops;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_s;
    logic             r_c;
    logic             r_sub;
    logic             r_vld;

    // ---- stage k input: preprocessed operands, or previous stage registers
    if (k == 0) begin : g_first
      assign w_a_in   = a;
      assign w_b_in   = w_b_eff;
      assign w_s_in   = '0;
      assign w_c_in   = w_c0;
      assign w_sub_in = sub;
      assign w_vld_in = in_valid;
    end else begin : g_next
      assign w_a_in   = g_stage[k-1].r_a;
      assign w_b_in   = g_stage[k-1].r_b;
      assign w_s_in   = g_stage[k-1].r_s;
      assign w_c_in   = g_stage[k-1].r_c;
      assign w_sub_in = g_stage[k-1].r_sub;
      assign w_vld_in = g_stage[k-1].r_vld;
    end

    // Already-consumed operand slices and the sub flag are carried but
    // not needed for arithmetic inside every stage.
    assign w_unused_ops = ^{w_a_in, w_b_in, w_sub_in};

    // Select-only carry chain: both block results are precomputed, the
    // incoming carry just picks one and forwards the matching carry.
    always_comb begin
      w_s_out = w_s_in;
      w_cc    = w_c_in;
      w_r0    = '0;
      w_r1    = '0;
      for (int j = 0; j < NPS; j++) begin
        w_r0 = rca(w_a_in[(k*NPS+j)*BLOCK +: BLOCK],
                   w_b_in[(k*NPS+j)*BLOCK +: BLOCK], 1'b0);
        w_r1 = rca(w_a_in[(k*NPS+j)*BLOCK +: BLOCK],
                   w_b_in[(k*NPS+j)*BLOCK +: BLOCK], 1'b1);
        w_s_out[(k*NPS+j)*BLOCK +: BLOCK] = w_cc ? w_r1[BLOCK-1:0]
                                                 : w_r0[BLOCK-1:0];
        w_cc = w_cc ? w_r1[BLOCK] : w_r0[BLOCK];
      end
      w_c_out = w_cc;
    end

    // ---- stage k register boundary
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_vld <= 1'b0;
      end else if (w_en) begin
        r_vld <= w_vld_in;
      end
    end

    // Bubbles leave the data registers untouched; only valid moves.
    always_ff @(posedge clk) begin
      if (w_en && w_vld_in) begin
        r_a   <= w_a_in;
        r_b   <= w_b_in;
        r_s   <= w_s_out;
        r_c   <= w_c_out;
        r_sub <= w_sub_in;
      end
    end
  end

  logic w_unused_last;

  assign out_valid = g_stage[STAGES-1].r_vld;
  assign w_en      = !out_valid || out_ready;
  assign in_ready  = w_en;

  // Results read as zero whenever nothing valid sits at the output, which
  // also gives the cleared outputs during and right after reset.
  assign sum     = out_valid ? g_stage[STAGES-1].r_s : '0;
  assign carry_o = out_valid & g_stage[STAGES-1].r_c;
  assign ovf     = out_valid &
                   (g_stage[STAGES-1].r_a[WIDTH-1] == g_stage[STAGES-1].r_b[WIDTH-1]) &
                   (g_stage[STAGES-1].r_s[WIDTH-1] != g_stage[STAGES-1].r_a[WIDTH-1]);

  assign w_unused_last = ^{g_stage[STAGES-1].r_a, g_stage[STAGES-1].r_b,
                           g_stage[STAGES-1].r_sub};

endmodule

// File: tb/tb_csa_pipe_addsub.sv
module tb_csa_pipe_addsub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        t_iv, t_ordy, t_ci, t_sub;
  logic [63:0] t_a, t_b;
  int          sel = 0;

  logic        ir0, ir1, ir2, ir3;
  logic        ov0, ov1, ov2, ov3;
  logic        co0, co1, co2, co3;
  logic        of0, of1, of2, of3;
  logic [15:0] sum0;
  logic [7:0]  sum1;
  logic [31:0] sum2;
  logic [63:0] sum3;

  csa_pipe_addsub #(.WIDTH(16), .BLOCK(4), .STAGES(2)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(t_iv && (sel == 0)), .in_ready(ir0),
    .a(t_a[15:0]), .b(t_b[15:0]), .carry_i(t_ci), .sub(t_sub),
    .out_valid(ov0), .out_ready(t_ordy), .sum(sum0), .carry_o(co0), .ovf(of0));

  csa_pipe_addsub #(.WIDTH(8), .BLOCK(4), .STAGES(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(t_iv && (sel == 1)), .in_ready(ir1),
    .a(t_a[7:0]), .b(t_b[7:0]), .carry_i(t_ci), .sub(t_sub),
    .out_valid(ov1), .out_ready(t_ordy), .sum(sum1), .carry_o(co1), .ovf(of1));

  csa_pipe_addsub #(.WIDTH(32), .BLOCK(4), .STAGES(4)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(t_iv && (sel == 2)), .in_ready(ir2),
    .a(t_a[31:0]), .b(t_b[31:0]), .carry_i(t_ci), .sub(t_sub),
    .out_valid(ov2), .out_ready(t_ordy), .sum(sum2), .carry_o(co2), .ovf(of2));

  csa_pipe_addsub #(.WIDTH(64), .BLOCK(8), .STAGES(2)) u3 (
    .clk(clk), .rst_n(rst_n), .in_valid(t_iv && (sel == 3)), .in_ready(ir3),
    .a(t_a), .b(t_b), .carry_i(t_ci), .sub(t_sub),
    .out_valid(ov3), .out_ready(t_ordy), .sum(sum3), .carry_o(co3), .ovf(of3));

  logic        cur_ir, cur_ov, cur_co, cur_of;
  logic [63:0] cur_sum;

  always_comb begin
    cur_ir = ir0; cur_ov = ov0; cur_co = co0; cur_of = of0; cur_sum = {48'd0, sum0};
    case (sel)
      1: begin cur_ir = ir1; cur_ov = ov1; cur_co = co1; cur_of = of1; cur_sum = {56'd0, sum1}; end
      2: begin cur_ir = ir2; cur_ov = ov2; cur_co = co2; cur_of = of2; cur_sum = {32'd0, sum2}; end
      3: begin cur_ir = ir3; cur_ov = ov3; cur_co = co3; cur_of = of3; cur_sum = sum3; end
      default: ;
    endcase
  end

  function automatic int cfg_w(input int c);
    case (c)
      1: return 8;
      2: return 32;
      3: return 64;
      default: return 16;
    endcase
  endfunction

  function automatic int cfg_s(input int c);
    case (c)
      1: return 1;
      2: return 4;
      default: return 2;
    endcase
  endfunction

  // Behavioural reference: plain wide addition, then mask to the width.
  // Result packing: [65]=ovf, [64]=carry out, [63:0]=sum.
  function automatic logic [65:0] model(input int w, input logic [63:0] x,
                                        input logic [63:0] y, input logic ci,
                                        input logic sb_);
    logic [64:0] mask, xm, ym, full;
    logic        c0, of;
    mask = (65'd1 << w) - 65'd1;
    xm   = {1'b0, x} & mask;
    ym   = (sb_ ? ~{1'b0, y} : {1'b0, y}) & mask;
    c0   = sb_ ? 1'b1 : ci;
    full = xm + ym + {64'd0, c0};
    of   = (xm[w-1] == ym[w-1]) && (full[w-1] != xm[w-1]);
    return {of, full[w], full[63:0] & mask[63:0]};
  endfunction

  typedef struct {
    logic [63:0] s;
    logic        co;
    logic        ov;
    int          acc_cyc;
    int          acc_stall;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc = 0;
  int          stall_cnt = 0;
  exp_t        mon_e;
  logic [65:0] mon_m;
  int          mon_lat, mon_exp_lat;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: push on accept, pop and compare on output transfer.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb.delete();
    end else begin
      if (cur_ov && t_ordy) begin
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL sb_spurious cfg=%0d got sum=%h, required no output", sel, cur_sum);
        end else begin
          mon_e = sb.pop_front();
          if (cur_sum !== mon_e.s || cur_co !== mon_e.co || cur_of !== mon_e.ov) begin
            n_fail++;
            $display("FAIL sb_result cfg=%0d got sum=%h co=%b ovf=%b, required sum=%h co=%b ovf=%b",
                     sel, cur_sum, cur_co, cur_of, mon_e.s, mon_e.co, mon_e.ov);
          end
          n_tests++;
          mon_lat     = cyc - mon_e.acc_cyc;
          mon_exp_lat = cfg_s(sel) + (stall_cnt - mon_e.acc_stall);
          if (mon_lat !== mon_exp_lat) begin
            n_fail++;
            $display("FAIL sb_latency cfg=%0d got %0d cycles, required %0d", sel, mon_lat, mon_exp_lat);
          end
        end
      end
      if (t_iv && cur_ir) begin
        mon_m = model(cfg_w(sel), t_a, t_b, t_ci, t_sub);
        sb.push_back('{mon_m[63:0], mon_m[64], mon_m[65], cyc, stall_cnt});
      end
      if (cur_ov && !t_ordy) stall_cnt++;
    end
  end

  task automatic test_reset();
    #2;
    n_tests++; if (ov0 !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got %b required 0", ov0); end
    n_tests++; if (sum0 !== 16'h0) begin n_fail++; $display("FAIL rst_sum got %h required 0000", sum0); end
    n_tests++; if (co0 !== 1'b0 || of0 !== 1'b0) begin
      n_fail++; $display("FAIL rst_flags got co=%b ovf=%b required 0 0", co0, of0);
    end
    @(posedge clk); #1;
    rst_n  = 1'b1;
    t_ordy = 1'b0;
    #1;
    n_tests++; if (ir0 !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready_empty got %b required 1", ir0); end
    n_tests++; if (ov0 !== 1'b0) begin n_fail++; $display("FAIL rst_release_valid got %b required 0", ov0); end
    t_ordy = 1'b1;
  endtask

  task automatic test_directed();
    logic [15:0] va [5] = '{16'h00FF, 16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000};
    logic [15:0] vb [5] = '{16'h0001, 16'h0001, 16'h0001, 16'h0007, 16'h0001};
    logic        vc [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic        vs [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [15:0] es [5] = '{16'h0100, 16'h0000, 16'h8000, 16'hFFFE, 16'h7FFF};
    logic        ec [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic        eo [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    sel = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      t_iv = 1'b1; t_a = {48'd0, va[i]}; t_b = {48'd0, vb[i]};
      t_ci = vc[i]; t_sub = vs[i]; t_ordy = 1'b1;
      @(negedge clk);
      n_tests++; if (ir0 !== 1'b1) begin n_fail++; $display("FAIL dir%0d_accept got in_ready=%b required 1", i, ir0); end
      @(posedge clk); #1;
      t_iv = 1'b0;
      @(negedge clk);
      n_tests++; if (ov0 !== 1'b0) begin n_fail++; $display("FAIL dir%0d_early got out_valid=%b required 0", i, ov0); end
      @(negedge clk);
      n_tests++; if (ov0 !== 1'b1) begin n_fail++; $display("FAIL dir%0d_latency got out_valid=%b required 1", i, ov0); end
      n_tests++;
      if (sum0 !== es[i] || co0 !== ec[i] || of0 !== eo[i]) begin
        n_fail++;
        $display("FAIL dir%0d_result got sum=%h co=%b ovf=%b required sum=%h co=%b ovf=%b",
                 i, sum0, co0, of0, es[i], ec[i], eo[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int          nxt = 1;
    int          got = 0;
    logic        seen = 1'b0;
    logic [15:0] held = '0;
    sel = 0;
    for (int c = 0; c < 40 && got < 8; c++) begin
      @(posedge clk); #1;
      t_iv   = (nxt <= 8);
      t_a    = 64'(nxt);
      t_b    = 64'(nxt);
      t_ci   = 1'b0;
      t_sub  = 1'b0;
      t_ordy = !(c >= 4 && c <= 6);
      @(negedge clk);
      if (c >= 4 && c <= 6) begin
        n_tests++; if (ir0 !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready c=%0d got %b required 0", c, ir0); end
        n_tests++; if (ov0 !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid c=%0d got %b required 1", c, ov0); end
        if (c == 4) held = sum0;
        else begin
          n_tests++; if (sum0 !== held) begin n_fail++; $display("FAIL bp_stable c=%0d got %h required %h", c, sum0, held); end
        end
      end else if (seen && got < 8) begin
        n_tests++; if (ov0 !== 1'b1) begin n_fail++; $display("FAIL bp_rate c=%0d got out_valid=%b required 1", c, ov0); end
      end
      if (ov0 && t_ordy) begin
        seen = 1'b1;
        n_tests++;
        if (sum0 !== 16'(2 * (got + 1))) begin
          n_fail++; $display("FAIL bp_order got %0d required %0d", sum0, 2 * (got + 1));
        end
        got++;
      end
      if (t_iv && ir0) nxt++;
    end
    n_tests++; if (got !== 8) begin n_fail++; $display("FAIL bp_count got %0d results required 8", got); end
    @(posedge clk); #1;
    t_iv = 1'b0; t_ordy = 1'b1;
  endtask

  task automatic test_reset_mid();
    sel = 0;
    @(posedge clk); #1;
    t_iv = 1'b1; t_a = 64'd1; t_b = 64'd2; t_ci = 1'b0; t_sub = 1'b0; t_ordy = 1'b1;
    @(posedge clk); #1;
    t_a = 64'd5; t_b = 64'd6;
    @(posedge clk); #1;
    t_iv = 1'b0;
    n_tests++; if (ov0 !== 1'b1) begin n_fail++; $display("FAIL rmid_inflight got out_valid=%b required 1", ov0); end
    rst_n = 1'b0;
    #1;
    n_tests++; if (ov0 !== 1'b0) begin n_fail++; $display("FAIL rmid_async got out_valid=%b required 0", ov0); end
    n_tests++; if (sum0 !== 16'h0) begin n_fail++; $display("FAIL rmid_sum got %h required 0000", sum0); end
    #4;
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_tests++; if (ov0 !== 1'b0) begin n_fail++; $display("FAIL rmid_dropped c=%0d got out_valid=%b required 0", c, ov0); end
    end
    @(posedge clk); #1;
    t_iv = 1'b1; t_a = 64'd3; t_b = 64'd4;
    @(posedge clk); #1;
    t_iv = 1'b0;
    @(negedge clk);
    n_tests++; if (ov0 !== 1'b0) begin n_fail++; $display("FAIL rmid_new_early got out_valid=%b required 0", ov0); end
    @(negedge clk);
    n_tests++;
    if (ov0 !== 1'b1 || sum0 !== 16'd7) begin
      n_fail++; $display("FAIL rmid_new got out_valid=%b sum=%0d required 1 7", ov0, sum0);
    end
  endtask

  task automatic test_random(input int cfg, input int n);
    @(posedge clk); #1;
    t_iv = 1'b0; t_ordy = 1'b1;
    sel = cfg;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      t_iv   = ($urandom_range(3) != 0);
      t_a    = {$urandom, $urandom};
      t_b    = {$urandom, $urandom};
      t_ci   = $urandom_range(1) == 1;
      t_sub  = $urandom_range(1) == 1;
      t_ordy = ($urandom_range(3) != 0);
    end
    @(posedge clk); #1;
    t_iv = 1'b0; t_ordy = 1'b1;
    for (int i = 0; i < 30 && sb.size() != 0; i++) @(posedge clk);
    #1;
    n_tests++;
    if (sb.size() !== 0) begin
      n_fail++; $display("FAIL rand_drain cfg=%0d got %0d outstanding required 0", cfg, sb.size());
    end
  endtask

  initial begin
    rst_n = 1'b0; t_iv = 1'b0; t_ordy = 1'b1; t_ci = 1'b0; t_sub = 1'b0;
    t_a = '0; t_b = '0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid();
    test_random(0, 1000);
    test_random(1, 3000);
    test_random(2, 3000);
    test_random(3, 3000);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached, tests run %0d", n_tests);
    $fatal(1, "watchdog");
  end

endmodule
